pc_branch_unit: RTL

- Program-counter and branch-resolution stage that sits directly downstream of the conditional-branch flag flip-flop.
- Owns the PC register and handles fetch increment and register jumps (jr/jal).
- On a branch request it drives the flag's load strobe and condition-select bits, samples the resulting flag, then commits PC <= PC + sign-extended C field, or leaves PC unchanged.
- Handshakes completion back to the control sequencer.

---
 rtl/pc_branch_unit_pkg.sv | 20 ++
 rtl/pc_branch_unit_branch_target_adder.sv | 19 +
 rtl/pc_branch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch-resolution stage.
package pc_branch_unit_pkg;

    // Instruction-register field positions
    localparam int unsigned COND_MSB = 20;
    localparam int unsigned COND_LSB = 19;
    localparam int unsigned IMM_MSB  = 18;

    // PC value loaded on reset unless the instance overrides it
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch-resolution sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_CON = 2'd1,
        SAMPLE   = 2'd2,
        UPDATE   = 2'd3
    } br_state_e;

endpackage

// File: rtl/pc_branch_unit_branch_target_adder.sv
// Branch target: PC plus sign-extended displacement, modulo 2^ADDR_WIDTH.
module branch_target_adder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IMM_WIDTH  = 19
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [IMM_WIDTH-1:0]  disp,
    output logic [ADDR_WIDTH-1:0] target
);

    logic [ADDR_WIDTH-1:0] disp_sext;

    // Sign-extend the displacement and add; carry out is discarded
    always_comb begin
        disp_sext = {{(ADDR_WIDTH - IMM_WIDTH){disp[IMM_WIDTH-1]}}, disp};
        target    = pc + disp_sext;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register with fetch increment, register jumps and conditional
// branch resolution through the external CON flag flip-flop.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned           IMM_WIDTH  = 19
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  pc_inc,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] bus_in,
    input  logic                  br_start,
    input  logic [31:0]           ir,
    input  logic                  con_in,
    output logic                  con_load,
    output logic [1:0]            cond_bits,
    output logic                  br_busy,
    output logic                  br_done,
    output logic                  br_taken,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] link_out
);

    br_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] link_q, link_d;
    logic [1:0]            cond_q, cond_d;
    logic [IMM_WIDTH-1:0]  disp_q, disp_d;
    logic                  br_taken_q, br_taken_d;
    logic [ADDR_WIDTH-1:0] target;
    logic                  unused_ir_bits;

    // Opcode/register fields above the condition bits are not used here
    assign unused_ir_bits = ^ir[31:COND_MSB+1];

    branch_target_adder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_target (
        .pc     (pc_q),
        .disp   (disp_q),
        .target (target)
    );

    // Next-state, PC update and branch bookkeeping
    // The flag is sampled and the PC committed on the same edge (leaving
    // SAMPLE), so the outcome register doubles as the held br_taken output.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        link_d     = link_q;
        cond_d     = cond_q;
        disp_d     = disp_q;
        br_taken_d = br_taken_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d   = bus_in;
                    link_d = pc_q;
                end else if (br_start) begin
                    state_d = LOAD_CON;
                    cond_d  = ir[COND_MSB:COND_LSB];
                    disp_d  = IMM_WIDTH'(ir[IMM_MSB:0]);
                    link_d  = pc_q;
                end else if (pc_inc) begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                end
            end
            LOAD_CON: state_d = SAMPLE;
            SAMPLE: begin
                state_d    = UPDATE;
                br_taken_d = con_in;
                if (con_in) begin
                    pc_d = target;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            link_q     <= '0;
            cond_q     <= '0;
            disp_q     <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            link_q     <= link_d;
            cond_q     <= cond_d;
            disp_q     <= disp_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign con_load  = (state_q == LOAD_CON);
    assign br_busy   = (state_q != IDLE);
    assign br_done   = (state_q == UPDATE);
    assign br_taken  = br_taken_q;
    assign cond_bits = cond_q;
    assign pc_out    = pc_q;
    assign link_out  = link_q;

endmodule
